// File: rtl/jk_pkg.sv
// Shared types, phase table and expected-value function for the JK flop drive/check harness.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam jk_t JK_PHASE [4] = '{JK_SET, JK_TGL, JK_HOLD, JK_RST};

  function automatic logic jk_next(input logic q, input jk_t jk);
    logic r;
    r = q;
    case (jk)
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

  // Channel ch runs the table delayed by ch phases.
  function automatic jk_t jk_pattern(input logic [1:0] ph, input int unsigned ch);
    logic [1:0] idx;
    idx = ph - 2'(ch);
    return JK_PHASE[idx];
  endfunction

endpackage

// File: rtl/jk_model_chk.sv
// One channel: expected JK flop state and Q/Q_ comparison against the readback.
module jk_model_chk
  import jk_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic upd_i,
  input  logic chk_i,
  input  jk_t  jk_i,
  input  logic q_i,
  input  logic qn_i,
  output logic mis_o
);

  logic exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (clr_i)      exp_d = 1'b0;
    else if (upd_i) exp_d = jk_next(exp_q, jk_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) exp_q <= 1'b0;
    else         exp_q <= exp_d;
  end

  // exp_q already reflects the J/K the DUT sampled at the previous edge.
  assign mis_o = chk_i & ((q_i != exp_q) | (qn_i != ~exp_q));

endmodule

// File: rtl/jk_drive_check.sv
// Drives a bank of JK flops through a fixed 4-phase J/K sequence and checks Q/Q_ against a model.
module jk_drive_check
  import jk_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned HOLD = 6,
  parameter int unsigned CW   = 8
) (
  input  logic          C,
  input  logic          R,
  input  logic          EN,
  output logic [N-1:0]  J,
  output logic [N-1:0]  K,
  output logic [N-1:0]  S_N,
  output logic [N-1:0]  R_N,
  input  logic [N-1:0]  Q,
  input  logic [N-1:0]  Q_N,
  output logic [1:0]    PH,
  output logic [CW-1:0] LOOPS,
  output logic          ERR,
  output logic [N-1:0]  ERR_CH,
  output logic [CW-1:0] ERR_CNT
);

  localparam int unsigned    HW        = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0]  SAT       = '1;

  state_t        st_q, st_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    ph_q, ph_d;
  logic [CW-1:0] loops_q, loops_d;
  logic          err_q, err_d;
  logic [N-1:0]  err_ch_q, err_ch_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]  j_q, j_d, k_q, k_d, rn_q, rn_d;
  logic [N-1:0]  mis;
  logic          mdl_clr, mdl_upd, run_chk;

  assign mdl_clr = EN & (st_q == ST_CLR);
  assign mdl_upd = EN & ((st_q == ST_SETTLE) | (st_q == ST_RUN));
  assign run_chk = EN & (st_q == ST_RUN);

  for (genvar g = 0; g < N; g++) begin : g_ch
    jk_model_chk u_chk (
      .clk_i  (C),
      .rst_ni (R),
      .clr_i  (mdl_clr),
      .upd_i  (mdl_upd),
      .chk_i  (run_chk),
      .jk_i   (jk_t'({j_q[g], k_q[g]})),
      .q_i    (Q[g]),
      .qn_i   (Q_N[g]),
      .mis_o  (mis[g])
    );
  end

  always_comb begin
    jk_t pat;
    pat       = JK_HOLD;
    st_d      = st_q;
    hold_d    = hold_q;
    ph_d      = ph_q;
    loops_d   = loops_q;
    err_d     = err_q;
    err_ch_d  = err_ch_q;
    err_cnt_d = err_cnt_q;
    rn_d      = '1;
    j_d       = '0;
    k_d       = '0;

    if (!EN) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_d      = ST_CLR;
          rn_d      = '0;
          hold_d    = '0;
          ph_d      = '0;
          loops_d   = '0;
          err_d     = 1'b0;
          err_ch_d  = '0;
          err_cnt_d = '0;
        end
        ST_CLR:    st_d = ST_SETTLE;
        ST_SETTLE: st_d = ST_RUN;
        ST_RUN: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            ph_d   = ph_q + 2'd1;
            if ((ph_q == 2'd3) && (loops_q != SAT)) loops_d = loops_q + CW'(1);
          end else begin
            hold_d = hold_q + HW'(1);
          end
          if (|mis) begin
            err_d    = 1'b1;
            err_ch_d = err_ch_q | mis;
            if (err_cnt_q != SAT) err_cnt_d = err_cnt_q + CW'(1);
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end

    // J/K are registered, so load the pattern for the phase the next cycle will be in.
    if (st_d == ST_RUN) begin
      for (int unsigned ch = 0; ch < N; ch++) begin
        pat     = jk_pattern(ph_d, ch);
        j_d[ch] = pat[1];
        k_d[ch] = pat[0];
      end
    end
  end

  always_ff @(posedge C) begin
    if (!R) begin
      st_q      <= ST_IDLE;
      hold_q    <= '0;
      ph_q      <= '0;
      loops_q   <= '0;
      err_q     <= 1'b0;
      err_ch_q  <= '0;
      err_cnt_q <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rn_q      <= '1;
    end else begin
      st_q      <= st_d;
      hold_q    <= hold_d;
      ph_q      <= ph_d;
      loops_q   <= loops_d;
      err_q     <= err_d;
      err_ch_q  <= err_ch_d;
      err_cnt_q <= err_cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rn_q      <= rn_d;
    end
  end

  assign J       = j_q;
  assign K       = k_q;
  assign S_N     = '1;
  assign R_N     = rn_q;
  assign PH      = ph_q;
  assign LOOPS   = loops_q;
  assign ERR     = err_q;
  assign ERR_CH  = err_ch_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_jk_drive_check.sv
// Directed bench: two harness instances (CW=8 and CW=2) each driving behavioural 74LS112-style flops.
module tb_jk_drive_check;

  logic       clk = 1'b0;
  logic       R, EN;
  logic [1:0] stuck, qn_eq;

  logic [1:0] ja, ka, sna, rna, pha, erra_ch, qa, qa_in, qna_in;
  logic [7:0] loopsa, erra_cnt;
  logic       erra;

  logic [1:0] jb, kb, snb, rnb, phb, errb_ch, qb, qnb;
  logic [1:0] loopsb, errb_cnt;
  logic       errb;

  int checks   = 0;
  int failures = 0;
  int rn_low   = 0;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] j;
    logic [1:0] k;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  assign qa_in  = qa | stuck;
  assign qna_in = (~qa & ~qn_eq) | (qa_in & qn_eq);
  assign qnb    = ~qb;

  jk_drive_check #(.N(2), .HOLD(6), .CW(8)) u_dut_a (
    .C(clk), .R(R), .EN(EN), .J(ja), .K(ka), .S_N(sna), .R_N(rna),
    .Q(qa_in), .Q_N(qna_in), .PH(pha), .LOOPS(loopsa), .ERR(erra),
    .ERR_CH(erra_ch), .ERR_CNT(erra_cnt)
  );

  jk_drive_check #(.N(2), .HOLD(6), .CW(2)) u_dut_b (
    .C(clk), .R(R), .EN(EN), .J(jb), .K(kb), .S_N(snb), .R_N(rnb),
    .Q(qb), .Q_N(qnb), .PH(phb), .LOOPS(loopsb), .ERR(errb),
    .ERR_CH(errb_ch), .ERR_CNT(errb_cnt)
  );

  // Behavioural JK flops with async active-low clear.
  for (genvar g = 0; g < 2; g++) begin : g_ff
    logic qf_a, qf_b;
    always @(posedge clk or negedge rna[g]) begin
      if (!rna[g]) qf_a <= 1'b0;
      else case ({ja[g], ka[g]})
        2'b10:   qf_a <= 1'b1;
        2'b01:   qf_a <= 1'b0;
        2'b11:   qf_a <= ~qf_a;
        default: qf_a <= qf_a;
      endcase
    end
    always @(posedge clk or negedge rnb[g]) begin
      if (!rnb[g]) qf_b <= 1'b0;
      else case ({jb[g], kb[g]})
        2'b10:   qf_b <= 1'b1;
        2'b01:   qf_b <= 1'b0;
        2'b11:   qf_b <= ~qf_b;
        default: qf_b <= qf_b;
      endcase
    end
    assign qa[g] = qf_a;
    assign qb[g] = qf_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rna != 2'b11) rn_low++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_J"},       ja,       0);
    chk({tag, "_K"},       ka,       0);
    chk({tag, "_S_N"},     sna,      2'b11);
    chk({tag, "_R_N"},     rna,      2'b11);
    chk({tag, "_PH"},      pha,      0);
    chk({tag, "_LOOPS"},   loopsa,   0);
    chk({tag, "_ERR"},     erra,     0);
    chk({tag, "_ERR_CH"},  erra_ch,  0);
    chk({tag, "_ERR_CNT"}, erra_cnt, 0);
    chk({tag, "_B_LOOPS"}, loopsb,   0);
    chk({tag, "_B_ERR"},   errb,     0);
  endtask

  initial begin
    // Expected {PH, J[1:0], K[1:0]} per phase; bit0 = channel 0, bit1 = channel 1.
    tbl[0] = '{2'd0, 2'b01, 2'b10};
    tbl[1] = '{2'd1, 2'b11, 2'b01};
    tbl[2] = '{2'd2, 2'b10, 2'b10};
    tbl[3] = '{2'd3, 2'b00, 2'b01};
    tbl[4] = '{2'd0, 2'b01, 2'b10};

    R = 1'b0; EN = 1'b0; stuck = 2'b00; qn_eq = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");

    // Golden run
    R = 1'b1; EN = 1'b1; rn_low = 0;
    step();
    chk("clr_R_N", rna, 2'b00);
    chk("clr_PH",  pha, 0);
    step();
    chk("settle_R_N", rna, 2'b11);
    chk("settle_JK",  {ja, ka}, 0);
    step();
    for (int c = 0; c <= 24; c++) begin
      chk($sformatf("pat_PH_c%0d", c), pha, tbl[c / 6].ph);
      chk($sformatf("pat_J_c%0d",  c), ja,  tbl[c / 6].j);
      chk($sformatf("pat_K_c%0d",  c), ka,  tbl[c / 6].k);
      if (c < 24) step();
    end
    chk("loop1_LOOPS", loopsa, 1);
    repeat (24) step();
    chk("loop2_B_LOOPS", loopsb, 2);
    repeat (24) step();
    chk("gold_LOOPS",   loopsa,   3);
    chk("gold_ERR",     erra,     0);
    chk("gold_ERR_CH",  erra_ch,  0);
    chk("gold_ERR_CNT", erra_cnt, 0);
    chk("gold_S_N",     sna,      2'b11);
    chk("gold_rn_low_cycles", rn_low, 1);
    chk("gold_B_LOOPS", loopsb,   3);
    repeat (48) step();
    chk("loop5_LOOPS",   loopsa, 5);
    chk("sat_B_LOOPS",   loopsb, 3);
    chk("sat_B_ERR",     errb,   0);

    // Channel 1 Q stuck at 1: counts only cycles where exp1=0
    EN = 1'b0;
    step();
    chk("idle_JK", {ja, ka}, 0);
    stuck = 2'b10; EN = 1'b1;
    step(); step(); step();
    repeat (24) step();
    chk("stuck_ERR_CNT_loop1", erra_cnt, 10);
    chk("stuck_ERR_CH",        erra_ch,  2'b10);
    chk("stuck_ERR",           erra,     1);
    chk("stuck_LOOPS",         loopsa,   1);
    repeat (15) step();
    chk("stuck_ERR_CNT_c39", erra_cnt, 17);
    chk("stuck_PH_c39",      pha,      2);

    // EN drop at phase 2, hold cycle 3
    stuck = 2'b00; EN = 1'b0;
    step();
    chk("endrop_J",       ja,       0);
    chk("endrop_K",       ka,       0);
    chk("endrop_R_N",     rna,      2'b11);
    chk("endrop_PH",      pha,      2);
    chk("endrop_LOOPS",   loopsa,   1);
    chk("endrop_ERR",     erra,     1);
    chk("endrop_ERR_CH",  erra_ch,  2'b10);
    chk("endrop_ERR_CNT", erra_cnt, 17);
    repeat (3) step();
    chk("frozen_ERR_CNT", erra_cnt, 17);
    chk("frozen_LOOPS",   loopsa,   1);
    EN = 1'b1;
    step();
    chk("restart_R_N",     rna,      2'b00);
    chk("restart_ERR",     erra,     0);
    chk("restart_ERR_CH",  erra_ch,  0);
    chk("restart_ERR_CNT", erra_cnt, 0);
    chk("restart_LOOPS",   loopsa,   0);
    chk("restart_PH",      pha,      0);

    // Single-cycle Q_N fault on channel 0
    step(); step();
    repeat (5) step();
    qn_eq = 2'b01;
    step();
    qn_eq = 2'b00;
    repeat (4) step();
    chk("qn_ERR_CNT", erra_cnt, 1);
    chk("qn_ERR_CH",  erra_ch,  2'b01);
    chk("qn_ERR",     erra,     1);
    chk("qn_PH",      pha,      1);

    // Reset mid-RUN with ERR set and EN still high
    R = 1'b0;
    step();
    check_reset("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
